// File: rtl/idecode32.sv
// idecode32 - instruction decode and register-file stage of the single-cycle
// MIPS CPU.
//
// Holds the 32 x 32-bit register file. Two combinational read ports are
// addressed by rs and rt, and the 16-bit immediate is extended for the ALU.
// On each rising clock edge the selected write-back value is committed:
// the ALU result, the load data, or the jal return address.
//
// Ports:
//   clock        in   1  rising-edge clock; register writes commit here
//   reset        in   1  synchronous, active-high; clears all registers
//   Instruction  in  32  current instruction from fetch
//   opcplus4     in  32  word address of PC+4 (byte address >> 2), used by jal
//   ALU_result   in  32  ALU write-back source
//   mem_data     in  32  load write-back source
//   Jal          in   1  instruction is jal: forces a write of the link to r31
//   RegWrite     in   1  write-back enable
//   MemtoReg     in   1  select mem_data as the write-back source
//   RegDst       in   1  1: write rd, 0: write rt
//   Read_data_1  out 32  value of register rs (also the jr target)
//   Read_data_2  out 32  value of register rt
//   Sign_extend  out 32  sign- or zero-extended immediate
module idecode32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] opcplus4,
    input  logic [31:0] ALU_result,
    input  logic [31:0] mem_data,
    input  logic        Jal,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        RegDst,
    output logic [31:0] Read_data_1,
    output logic [31:0] Read_data_2,
    output logic [31:0] Sign_extend
);

    // Logical immediates (andi/ori/xori) and sltiu take a zero-extended
    // immediate; every other opcode sign-extends it.
    function automatic logic [31:0] extend_imm(input logic [5:0] opcode,
                                               input logic [15:0] imm);
        logic zero_ext;
        zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) ||
                   (opcode == 6'h0E) || (opcode == 6'h0B);
        if (zero_ext)
            extend_imm = {16'h0000, imm};
        else
            extend_imm = {{16{imm[15]}}, imm};
    endfunction

    logic [5:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [15:0] imm;

    assign opcode  = Instruction[31:26];
    assign rs_addr = Instruction[25:21];
    assign rt_addr = Instruction[20:16];
    assign rd_addr = Instruction[15:11];
    assign imm     = Instruction[15:0];

    // The link value is a word address; its top two bits drop out when it is
    // turned back into a byte address.
    logic unused_opc_hi;
    assign unused_opc_hi = ^opcplus4[31:30];

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // Jal overrides the controller's destination and source selects.
    always_comb begin
        wr_en   = RegWrite | Jal;
        wr_addr = rt_addr;
        wr_data = ALU_result;
        if (Jal) begin
            wr_addr = 5'd31;
            wr_data = {opcplus4[29:0], 2'b00};
        end else begin
            if (RegDst)
                wr_addr = rd_addr;
            if (MemtoReg)
                wr_data = mem_data;
        end
    end

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Reset wins over a concurrent write. Entry 0 is forced to zero on every
    // edge so that writes to it are discarded.
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs_d[i] = '0;
        end else if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    // Reads are unbypassed: a same-cycle write shows up only after the edge.
    // r0 is gated so it reads 0 even before the first reset.
    assign Read_data_1 = (rs_addr == 5'd0) ? 32'h0 : regs_q[rs_addr];
    assign Read_data_2 = (rt_addr == 5'd0) ? 32'h0 : regs_q[rt_addr];
    assign Sign_extend = extend_imm(opcode, imm);

endmodule

// File: tb/tb_idecode32.sv
// tb_idecode32 - self-checking bench for idecode32.
// Expected values are pushed to a scoreboard queue as stimulus is driven and
// popped when the corresponding DUT output is sampled.
module tb_idecode32;

    logic        clock;
    logic        reset;
    logic [31:0] Instruction;
    logic [31:0] opcplus4;
    logic [31:0] ALU_result;
    logic [31:0] mem_data;
    logic        Jal;
    logic        RegWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic [31:0] Sign_extend;

    idecode32 dut (
        .clock       (clock),
        .reset       (reset),
        .Instruction (Instruction),
        .opcplus4    (opcplus4),
        .ALU_result  (ALU_result),
        .mem_data    (mem_data),
        .Jal         (Jal),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .Read_data_1 (Read_data_1),
        .Read_data_2 (Read_data_2),
        .Sign_extend (Sign_extend)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", got, 32'hxxxx_xxxx);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, got, e.exp);
        end
    endtask

    // One write cycle: drive on the falling edge, commit on the rising edge,
    // then drop the enables.
    task automatic do_write(input logic [31:0] instr, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [31:0] pc4,
                            input logic rw, input logic rdst,
                            input logic m2r, input logic jal);
        @(negedge clock);
        Instruction = instr;
        ALU_result  = alu;
        mem_data    = mem;
        opcplus4    = pc4;
        RegWrite    = rw;
        RegDst      = rdst;
        MemtoReg    = m2r;
        Jal         = jal;
        @(posedge clock);
        #1;
        RegWrite = 1'b0;
        Jal      = 1'b0;
    endtask

    // Combinational read of two registers with writes disabled.
    task automatic read_regs(input int rs, input int rt,
                             input logic [31:0] exp1, input logic [31:0] exp2,
                             input string tag);
        logic [4:0] a;
        logic [4:0] b;
        a = rs[4:0];
        b = rt[4:0];
        sb_push({tag, "_rd1"}, exp1);
        sb_push({tag, "_rd2"}, exp2);
        Instruction = {6'h00, a, b, 16'h0000};
        #1;
        sb_pop_check(Read_data_1);
        sb_pop_check(Read_data_2);
    endtask

    task automatic check_ext(input logic [5:0] op, input logic [15:0] imm_v,
                             input logic [31:0] exp, input string tag);
        sb_push(tag, exp);
        Instruction = {op, 10'h000, imm_v};
        #1;
        sb_pop_check(Sign_extend);
    endtask

    initial begin
        reset       = 1'b1;
        Instruction = '0;
        opcplus4    = '0;
        ALU_result  = '0;
        mem_data    = '0;
        Jal         = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state.
        for (int i = 0; i < 32; i++)
            read_regs(i, 31 - i, 32'h0, 32'h0, $sformatf("init_r%0d", i));

        // r5 = DEADBEEF via rd, then reset with a concurrent write to r6.
        do_write({6'h00, 5'd0, 5'd0, 5'd5, 11'h020}, 32'hDEADBEEF, 32'h0, 32'h0,
                 1'b1, 1'b1, 1'b0, 1'b0);
        read_regs(5, 0, 32'hDEADBEEF, 32'h0, "pre_reset_r5");
        @(negedge clock);
        reset       = 1'b1;
        Instruction = {6'h00, 5'd0, 5'd0, 5'd6, 11'h020};
        ALU_result  = 32'h11111111;
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        RegWrite = 1'b0;
        read_regs(5, 6, 32'h0, 32'h0, "reset_r5_r6");
        for (int i = 0; i < 32; i++)
            read_regs(i, (i + 7) % 32, 32'h0, 32'h0, $sformatf("reset_r%0d", i));

        // R-type write to rd.
        do_write(32'h01095020, 32'h12345678, 32'hAAAA5555, 32'h0,
                 1'b1, 1'b1, 1'b0, 1'b0);
        read_regs(10, 9, 32'h12345678, 32'h0, "rtype_r10");

        // Same-cycle read/write of r10 (add r10,r10,r9): old before, new after.
        @(negedge clock);
        Instruction = 32'h01495020;
        ALU_result  = 32'h55AA55AA;
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        MemtoReg    = 1'b0;
        sb_push("same_cycle_before", 32'h12345678);
        #1;
        sb_pop_check(Read_data_1);
        @(posedge clock);
        #1;
        sb_push("same_cycle_after", 32'h55AA55AA);
        sb_pop_check(Read_data_1);
        RegWrite = 1'b0;

        // Load write to rt; ALU_result must be ignored.
        do_write(32'h8C0B0004, 32'h0BAD0BAD, 32'hCAFEF00D, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0);
        read_regs(11, 10, 32'hCAFEF00D, 32'h55AA55AA, "lw_r11");

        // jal link into r31, RegWrite=0, other selects ignored.
        do_write(32'h0C000011, 32'h77777777, 32'h66666666, 32'h00000011,
                 1'b0, 1'b1, 1'b1, 1'b1);
        read_regs(31, 0, 32'h00000044, 32'h0, "jal_r31");
        // Upper bits of opcplus4 are dropped by the shift.
        do_write(32'h0C000011, 32'h0, 32'h0, 32'hC0000003,
                 1'b0, 1'b0, 1'b0, 1'b1);
        read_regs(31, 11, 32'h0000000C, 32'hCAFEF00D, "jal_r31_wrap");

        // Writes to r0 are discarded.
        do_write(32'h00000020, 32'hFFFFFFFF, 32'h0, 32'h0,
                 1'b1, 1'b1, 1'b0, 1'b0);
        read_regs(0, 0, 32'h0, 32'h0, "r0_protect");

        // RegWrite=0 writes nothing.
        do_write({6'h00, 5'd0, 5'd0, 5'd12, 11'h020}, 32'h13579BDF, 32'h0, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0);
        read_regs(12, 10, 32'h0, 32'h55AA55AA, "no_write_r12");

        // Immediate extension.
        check_ext(6'h08, 16'h8000, 32'hFFFF8000, "ext_addi");
        check_ext(6'h0D, 16'h8000, 32'h00008000, "ext_ori");
        check_ext(6'h04, 16'h7FFF, 32'h00007FFF, "ext_beq");
        check_ext(6'h0C, 16'hF00F, 32'h0000F00F, "ext_andi");
        check_ext(6'h0E, 16'h8001, 32'h00008001, "ext_xori");
        check_ext(6'h0B, 16'hFFFF, 32'h0000FFFF, "ext_sltiu");
        check_ext(6'h0A, 16'hFFFF, 32'hFFFFFFFF, "ext_slti");
        check_ext(6'h23, 16'h8004, 32'hFFFF8004, "ext_lw");

        if (sb_q.size() != 0)
            check_val("scoreboard_leftover", sb_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
